// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for a word-wide data RAM.
// - Sub-word stores are done as a read-modify-write.
// - Sub-word loads extract the addressed lane and sign- or zero-extend it.
// - Misaligned requests are answered with addr_err and never touch the RAM.
module mem_access_ctrl #(
    parameter int RAM_AW = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              done,
    output logic              addr_err,
    output logic [RAM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd,
    output logic              mem_read,
    output logic              mem_write
);

    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sign_ext;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_req_t;

    state_t   state, nxt;
    acc_req_t r;
    logic     err;
    logic     misaligned;
    logic [31:0] word;
    logic [31:0] shifted;
    logic [31:0] ld_val;

    logic [NUM_LANES-1:0][7:0] cur_b, rep_b, mrg_b;
    logic [NUM_LANES-1:0]      be;

    // Alignment is judged on the live request, at the moment it is accepted.
    assign misaligned = (size == 2'b11) ||
                        (size == 2'b01 && addr[0]) ||
                        (size == 2'b10 && addr[1:0] != 2'b00);

    // Next-state selection; the request is only looked at in IDLE.
    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (misaligned)          nxt = RESP;
                    else if (!we)            nxt = RD;
                    else if (size == 2'b10)  nxt = WR;
                    else                     nxt = RD;
                end
            end
            RD:      nxt = r.we ? WR : RESP;
            WR:      nxt = RESP;
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // State, captured request, RAM read word and load result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            r     <= '0;
            err   <= 1'b0;
            word  <= '0;
            rdata <= '0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: begin
                    if (req) begin
                        r.we       <= we;
                        r.size     <= size;
                        r.sign_ext <= sign_ext;
                        r.addr     <= addr;
                        r.wdata    <= wdata;
                        err        <= misaligned;
                        if (misaligned) rdata <= '0;
                    end
                end
                RD: begin
                    word <= mem_rd;
                    if (!r.we) rdata <= ld_val;
                end
                default: ;
            endcase
        end
    end

    // Lane extraction and extension of the word coming back from the RAM.
    // A half is always at offset 0 or 2, so one byte-granular shift covers both.
    always_comb begin
        shifted = mem_rd >> {r.addr[1:0], 3'b000};
        case (r.size)
            2'b00:   ld_val = {{24{r.sign_ext & shifted[7]}},  shifted[7:0]};
            2'b01:   ld_val = {{16{r.sign_ext & shifted[15]}}, shifted[15:0]};
            default: ld_val = mem_rd;
        endcase
    end

    // Byte enables for the lane being stored.
    always_comb begin
        be = '0;
        case (r.size)
            2'b00:   be = 4'b0001 << r.addr[1:0];
            2'b01:   be = r.addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    assign cur_b = word;
    assign rep_b = (r.size == 2'b00) ? {4{r.wdata[7:0]}} : {2{r.wdata[15:0]}};

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign mrg_b[k] = be[k] ? rep_b[k] : cur_b[k];
    end

    // RAM strobes; reset masks both so an aborted access never commits.
    always_comb begin
        mem_read  = (state == RD) && !reset;
        mem_write = (state == WR) && !reset;
        mem_wd    = '0;
        if (state == WR)
            mem_wd = (r.size == 2'b10) ? r.wdata : mrg_b;
    end

    assign mem_addr = r.addr[RAM_AW+1:2];
    assign done     = (state == RESP);
    assign addr_err = (state == RESP) && err;
    assign stall    = req && !done;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle access sequencer between the CPU's load/store unit and the word-wide data memory (32-bit RAM port with RD/WD/address/MemRead/MemWrite). It turns byte, halfword and word loads and stores into memory cycles: a read-modify-write for sub-word stores, and lane extraction plus sign or zero extension for sub-word loads. It stalls the CPU until the access completes and flags misaligned accesses without touching memory.

## Interface
- RAM_AW, default 10: word-address width of the data RAM. The RAM holds 2^RAM_AW 32-bit words.
- clk, in, 1: single clock. All state changes on its rising edge.
- reset, in, 1: synchronous, active-high.
- req, in, 1: access request. The CPU holds it, with the qualifiers below, stable until `done`.
- we, in, 1: 1 = store, 0 = load.
- size, in, 2: 00 = byte, 01 = half, 10 = word, 11 = illegal (treated as misaligned).
- sign_ext, in, 1: loads only; 1 = sign-extend, 0 = zero-extend.
- addr, in, 32: byte address.
- wdata, in, 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- rdata, out, 32: load result, valid only while `done`=1. Holds its value otherwise.
- stall, out, 1: combinational; = req & ~done.
- done, out, 1: one-cycle completion pulse.
- addr_err, out, 1: valid with `done`. 1 = access rejected.
- mem_addr, out, RAM_AW: word address = addr[RAM_AW+1:2]. Upper address bits are ignored (wrap-around).
- mem_wd, out, 32: RAM write data.
- mem_rd, in, 32: RAM read data, combinational from mem_addr while mem_read=1.
- mem_read, out, 1: RAM output enable.
- mem_write, out, 1: RAM write strobe. The RAM writes mem_wd at the rising edge where mem_write=1.

## Operation
- FSM states: IDLE, RD, WR, RESP.
- **IDLE:**
  - On req=1, register we/size/sign_ext/addr/wdata.
  - Misaligned access → RESP with err=1. Misaligned means: size=11; half with addr[0]=1; word with addr[1:0]≠00.
  - Otherwise: load → RD; word store → WR; byte/half store → RD.
- **RD:**
  - mem_read=1; capture mem_rd into an internal word register.
  - Load → RESP. Sub-word store → WR.
- **WR:**
  - mem_write=1.
  - Word store: mem_wd = wdata.
  - Sub-word store: mem_wd = captured word with the target lane replaced.
  - Next state RESP.
- **RESP:** done=1, addr_err=err, rdata driven. Next state IDLE unconditionally.
- **Lane selection (little-endian):**
  - Byte at offset k occupies bits [8k+7:8k].
  - Half with addr[1]=0 is [15:0]; with addr[1]=1 it is [31:16].
- **Load extension:** the lane is placed in the LSBs; the upper bits are filled with the lane MSB if sign_ext=1, else zeros. Word loads ignore sign_ext.
- **Errored access:** rdata=0, no mem_read or mem_write ever asserted.
- **Outputs outside their states:** mem_read, mem_write and mem_wd are 0.
- **Strobe gating:** mem_write = (state==WR) & ~reset, so a reset cycle never commits a write.
- **Reset:**
  - state=IDLE; done=0, addr_err=0, rdata=0.
  - Internal registers cleared; mem_read=mem_write=0.
  - Reset mid-operation aborts the access. A partially completed sub-word store leaves RAM unchanged because WR was not committed.
- **Qualifier changes:** changes to req/qualifiers after acceptance are ignored until RESP.

## Timing
- Acceptance edge = the first rising edge with state=IDLE and req=1. Cycle counts below are cycles after that edge in which done=1.
- Cycles to done:
  - Load: 2 (RD, RESP).
  - Word store: 2 (WR, RESP).
  - Sub-word store: 3 (RD, WR, RESP).
  - Error: 1 (RESP).
- stall is high from req assertion through the cycle before RESP, and low during RESP.
- Back-to-back accesses: after RESP the FSM spends one IDLE cycle. req still high there is treated as the next instruction's access, so there is one bubble cycle between accesses.
- Simultaneous reset and req: reset wins and the request is not accepted.

## Test plan
- **Word store then load.** reset; sw addr=0x10 wdata=0xDEADBEEF → mem_write one cycle with mem_addr=4, mem_wd=0xDEADBEEF; done 2 cycles after acceptance. Then lw 0x10 → rdata=0xDEADBEEF, addr_err=0.
- **Byte store read-modify-write.** RAM[4]=0xDEADBEEF; sb addr=0x12 wdata=0x55 → RD then WR with mem_wd=0xDE55BEEF; done at cycle 3. Then lb 0x12 → 0x00000055.
- **Sign/zero extension.** RAM[4]=0x80F0FF7F:
  - lb 0x13 sign → 0xFFFFFF80.
  - lbu 0x13 → 0x00000080.
  - lh 0x12 sign → 0xFFFF80F0.
  - lhu 0x10 → 0x0000FF7F.
- **Misalignment.** lw 0x11, sh 0x13, size=11 → each gives done 1 cycle after acceptance, addr_err=1, rdata=0, mem_read/mem_write never high, RAM unchanged.
- **Reset mid-store.** sh 0x20 accepted; assert reset in the WR cycle → mem_write stays 0, RAM[8] unchanged, next cycle state=IDLE and all outputs 0.
- **Back-to-back and wrap.** With RAM_AW=10, hold req high across sw 0x1000 (wraps to mem_addr=0) then lw 0x0 → stall pattern 1,0 (RESP),1,1,0; the load returns the stored word.
